// File: rtl/hazard_pkg.sv
// Shared types for the MIPS hazard controller: forwarding selects, Tuse/Tnew
// encodings, the per-stage shadow record and small compare helpers.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_t;

    // Tuse: stage in which the operand is first consumed.
    localparam logic [1:0] TUSE_D = 2'd0;
    localparam logic [1:0] TUSE_E = 2'd1;
    localparam logic [1:0] TUSE_M = 2'd2;

    // Tnew: cycles after entering E until the result can be forwarded.
    localparam logic [1:0] TNEW_RDY  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t   dst;
        logic [1:0] tnew;
        reg_idx_t   rs;
        reg_idx_t   rt;
        logic       rs_use;
        logic       rt_use;
        logic       md;
        logic       div;
    } stage_t;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == TNEW_RDY) ? TNEW_RDY : t - 2'd1;
    endfunction

    // $0 is hardwired, so it never matches a producer.
    function automatic logic src_hit(input reg_idx_t dst, input reg_idx_t src);
        return (src != 5'd0) && (dst == src);
    endfunction

    function automatic fwd_sel_t fwd_select(input logic e_rdy, input logic m_rdy,
                                            input logic w_rdy);
        if (e_rdy)
            return FWD_E;
        else if (m_rdy)
            return FWD_M;
        else if (w_rdy)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage hazard request bundle and the controller's stall/forward responses.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    reg_idx_t   d_rs;
    reg_idx_t   d_rt;
    logic       d_rs_use;
    logic       d_rt_use;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    reg_idx_t   d_dst;
    logic [1:0] d_tnew;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;

    logic       stall;
    fwd_sel_t   fwd_d_rs;
    fwd_sel_t   fwd_d_rt;
    fwd_sel_t   fwd_e_rs;
    fwd_sel_t   fwd_e_rt;
    logic       md_busy;

    modport master (
        output d_rs, d_rt, d_rs_use, d_rt_use, d_tuse_rs, d_tuse_rt,
               d_dst, d_tnew, d_md_start, d_md_div, d_md_use,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_rs_use, d_rt_use, d_tuse_rs, d_tuse_rt,
               d_dst, d_tnew, d_md_start, d_md_div, d_md_use,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
    );

endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Multiply/divide busy window: loads the op latency as the op leaves E,
// then counts down to zero; busy while nonzero.
module md_busy_cnt #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_div,
    output logic busy
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples its inputs as they were before the edge.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage MIPS pipeline. Define FWD_EN to
// enable bypassing; otherwise consumers wait until the producer has written back.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave bus
);

    stage_t     d_fields;
    stage_t     e_q;
    reg_idx_t   m_dst;
    logic [1:0] m_tnew;
    reg_idx_t   w_dst;

    logic       rs_stall;
    logic       rt_stall;
    logic       md_stall;
    logic       stall;
    logic       md_busy;

    fwd_sel_t   fwd_d_rs;
    fwd_sel_t   fwd_d_rt;
    fwd_sel_t   fwd_e_rs;
    fwd_sel_t   fwd_e_rt;

    assign d_fields = '{
        dst:    bus.d_dst,
        tnew:   bus.d_tnew,
        rs:     bus.d_rs,
        rt:     bus.d_rt,
        rs_use: bus.d_rs_use,
        rt_use: bus.d_rt_use,
        md:     bus.d_md_start,
        div:    bus.d_md_div
    };

    // Shadow pipeline; a stalled D slot turns into an all-zero bubble in E.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= '0;
            m_dst  <= '0;
            m_tnew <= '0;
            w_dst  <= '0;
        end else begin
            w_dst  <= m_dst;
            m_dst  <= e_q.dst;
            m_tnew <= tnew_dec(e_q.tnew);
            e_q    <= stall ? '0 : d_fields;
        end
    end

`ifdef FWD_EN
    assign rs_stall = bus.d_rs_use &&
        ((src_hit(e_q.dst, bus.d_rs) && (e_q.tnew > bus.d_tuse_rs)) ||
         (src_hit(m_dst,   bus.d_rs) && (m_tnew   > bus.d_tuse_rs)));
    assign rt_stall = bus.d_rt_use &&
        ((src_hit(e_q.dst, bus.d_rt) && (e_q.tnew > bus.d_tuse_rt)) ||
         (src_hit(m_dst,   bus.d_rt) && (m_tnew   > bus.d_tuse_rt)));

    always_comb begin
        fwd_d_rs = fwd_select(src_hit(e_q.dst, bus.d_rs) && (e_q.tnew == TNEW_RDY),
                              src_hit(m_dst,   bus.d_rs) && (m_tnew   == TNEW_RDY),
                              src_hit(w_dst,   bus.d_rs));
        fwd_d_rt = fwd_select(src_hit(e_q.dst, bus.d_rt) && (e_q.tnew == TNEW_RDY),
                              src_hit(m_dst,   bus.d_rt) && (m_tnew   == TNEW_RDY),
                              src_hit(w_dst,   bus.d_rt));
        // E operands can only be sourced from older stages (M, then W).
        fwd_e_rs = fwd_select(1'b0,
                              e_q.rs_use && src_hit(m_dst, e_q.rs) && (m_tnew == TNEW_RDY),
                              e_q.rs_use && src_hit(w_dst, e_q.rs));
        fwd_e_rt = fwd_select(1'b0,
                              e_q.rt_use && src_hit(m_dst, e_q.rt) && (m_tnew == TNEW_RDY),
                              e_q.rt_use && src_hit(w_dst, e_q.rt));
    end
`else
    // No bypass network and no regfile write-through: hold until past W.
    assign rs_stall = bus.d_rs_use &&
        (src_hit(e_q.dst, bus.d_rs) || src_hit(m_dst, bus.d_rs) || src_hit(w_dst, bus.d_rs));
    assign rt_stall = bus.d_rt_use &&
        (src_hit(e_q.dst, bus.d_rt) || src_hit(m_dst, bus.d_rt) || src_hit(w_dst, bus.d_rt));

    assign fwd_d_rs = FWD_RF;
    assign fwd_d_rt = FWD_RF;
    assign fwd_e_rs = FWD_RF;
    assign fwd_e_rt = FWD_RF;

    logic unused_fwd_fields;
    assign unused_fwd_fields = ^{bus.d_tuse_rs, bus.d_tuse_rt, m_tnew,
                                 e_q.rs, e_q.rt, e_q.rs_use, e_q.rt_use};
`endif

    assign md_stall = bus.d_md_use && (e_q.md || md_busy);
    assign stall    = rs_stall || rt_stall || md_stall;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (e_q.md),
        .load_div (e_q.div),
        .busy     (md_busy)
    );

    assign bus.stall    = stall;
    assign bus.fwd_d_rs = fwd_d_rs;
    assign bus.fwd_d_rt = fwd_d_rt;
    assign bus.fwd_e_rs = fwd_e_rs;
    assign bus.fwd_e_rt = fwd_e_rt;
    assign bus.md_busy  = md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow the FWD_EN build setting.
module tb_hazard_ctrl;
    import hazard_pkg::*;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    hazard_ctrl_if bus ();

    hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic rs_use, input logic rt_use,
                         input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
                         input logic [4:0] dst, input logic [1:0] tnew,
                         input logic md_start, input logic md_div, input logic md_use);
        bus.d_rs       = rs;
        bus.d_rt       = rt;
        bus.d_rs_use   = rs_use;
        bus.d_rt_use   = rt_use;
        bus.d_tuse_rs  = tuse_rs;
        bus.d_tuse_rt  = tuse_rt;
        bus.d_dst      = dst;
        bus.d_tnew     = tnew;
        bus.d_md_start = md_start;
        bus.d_md_div   = md_div;
        bus.d_md_use   = md_use;
        #1;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 1'b0, 1'b0, TUSE_D, TUSE_D, 5'd0, TNEW_RDY, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        nop();
        repeat (4) tick();
    endtask

    // n cycles of stall, then the stall must drop with the same D instruction held.
    task automatic expect_stall(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_stall"}, bus.stall, 1);
            tick();
        end
        check({tag, "_go"}, bus.stall, 0);
    endtask

    // MDU op then a HI/LO consumer: 1 + n stall cycles, md_busy for n of them.
    task automatic md_seq(input string tag, input logic is_div, input int n);
        set_d(5'd8, 5'd9, 1'b1, 1'b1, TUSE_E, TUSE_E, 5'd0, TNEW_RDY, 1'b1, is_div, 1'b1);
        check({tag, "_start_stall"}, bus.stall, 0);
        tick();
        set_d(5'd0, 5'd0, 1'b0, 1'b0, TUSE_D, TUSE_D, 5'd2, TNEW_ALU, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= n; i++) begin
            check({tag, "_stall"}, bus.stall, 1);
            check({tag, "_busy"}, bus.md_busy, (i == 0) ? 0 : 1);
            tick();
        end
        check({tag, "_end_stall"}, bus.stall, 0);
        check({tag, "_end_busy"}, bus.md_busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nop();
        repeat (2) tick();
        reset = 1'b0;
        check("rst_stall", bus.stall, 0);
        check("rst_fwd_d_rs", bus.fwd_d_rs, FWD_RF);
        check("rst_fwd_d_rt", bus.fwd_d_rt, FWD_RF);
        check("rst_fwd_e_rs", bus.fwd_e_rs, FWD_RF);
        check("rst_fwd_e_rt", bus.fwd_e_rt, FWD_RF);
        check("rst_md_busy", bus.md_busy, 0);

        // lw $1 in E, add $2,$1,$3 in D
        set_d(5'd0, 5'd0, 1'b1, 1'b0, TUSE_E, TUSE_E, 5'd1, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd1, 5'd3, 1'b1, 1'b1, TUSE_E, TUSE_E, 5'd2, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        check("lw_add_fwd_d_rs", bus.fwd_d_rs, FWD_RF);
        expect_stall("lw_add", FWD ? 1 : 3);
        tick();
        nop();
        check("lw_add_fwd_e_rs", bus.fwd_e_rs, FWD ? 3 : 0);
        check("lw_add_fwd_e_rt", bus.fwd_e_rt, FWD_RF);
        flush();

        // ori $1 in E, beq $1,$1 in D
        set_d(5'd0, 5'd0, 1'b1, 1'b0, TUSE_E, TUSE_E, 5'd1, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd1, 5'd1, 1'b1, 1'b1, TUSE_D, TUSE_D, 5'd0, TNEW_RDY, 1'b0, 1'b0, 1'b0);
        expect_stall("ori_beq", FWD ? 1 : 3);
        check("ori_beq_fwd_d_rs", bus.fwd_d_rs, FWD ? 2 : 0);
        check("ori_beq_fwd_d_rt", bus.fwd_d_rt, FWD ? 2 : 0);
        tick();
        flush();

        // jal in E, jr $31 in D
        set_d(5'd0, 5'd0, 1'b0, 1'b0, TUSE_D, TUSE_D, 5'd31, TNEW_RDY, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd31, 5'd0, 1'b1, 1'b0, TUSE_D, TUSE_D, 5'd0, TNEW_RDY, 1'b0, 1'b0, 1'b0);
        expect_stall("jal_jr", FWD ? 0 : 3);
        check("jal_jr_fwd_d_rs", bus.fwd_d_rs, FWD ? 1 : 0);
        tick();
        flush();

        // add $0,$4,$5 in E, consumer of $0 in D
        set_d(5'd4, 5'd5, 1'b1, 1'b1, TUSE_E, TUSE_E, 5'd0, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 1'b1, 1'b1, TUSE_D, TUSE_D, 5'd0, TNEW_RDY, 1'b0, 1'b0, 1'b0);
        check("r0_stall", bus.stall, 0);
        check("r0_fwd_d_rs", bus.fwd_d_rs, FWD_RF);
        check("r0_fwd_d_rt", bus.fwd_d_rt, FWD_RF);
        tick();
        check("r0_stall2", bus.stall, 0);
        check("r0_fwd_d_rs2", bus.fwd_d_rs, FWD_RF);
        check("r0_fwd_e_rs", bus.fwd_e_rs, FWD_RF);
        check("r0_fwd_e_rt", bus.fwd_e_rt, FWD_RF);
        flush();

        // ori $1 in E, add $2,$1,$1 in D (tuse 1)
        set_d(5'd0, 5'd0, 1'b1, 1'b0, TUSE_E, TUSE_E, 5'd1, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd1, 5'd1, 1'b1, 1'b1, TUSE_E, TUSE_E, 5'd2, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        expect_stall("ori_add", FWD ? 0 : 3);
        check("ori_add_fwd_d_rs", bus.fwd_d_rs, FWD_RF);
        tick();
        nop();
        check("ori_add_fwd_e_rs", bus.fwd_e_rs, FWD ? 2 : 0);
        check("ori_add_fwd_e_rt", bus.fwd_e_rt, FWD ? 2 : 0);
        flush();

        md_seq("div", 1'b1, 10);
        flush();
        md_seq("mult", 1'b0, 5);
        flush();

        // reset while a divide is counting and a consumer is stalled
        set_d(5'd8, 5'd9, 1'b1, 1'b1, TUSE_E, TUSE_E, 5'd0, TNEW_RDY, 1'b1, 1'b1, 1'b1);
        tick();
        set_d(5'd0, 5'd0, 1'b0, 1'b0, TUSE_D, TUSE_D, 5'd2, TNEW_ALU, 1'b0, 1'b0, 1'b1);
        check("mid_rst_pre_stall", bus.stall, 1);
        repeat (4) tick();
        check("mid_rst_cnt7_busy", bus.md_busy, 1);
        check("mid_rst_cnt7_stall", bus.stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", bus.md_busy, 0);
        check("mid_rst_stall", bus.stall, 0);

        // shadow registers must be cleared by reset
        set_d(5'd0, 5'd0, 1'b0, 1'b0, TUSE_D, TUSE_D, 5'd1, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd1, 5'd0, 1'b1, 1'b0, TUSE_D, TUSE_D, 5'd0, TNEW_RDY, 1'b0, 1'b0, 1'b0);
        check("shadow_pre_stall", bus.stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("shadow_rst_stall", bus.stall, 0);
        check("shadow_rst_fwd_d_rs", bus.fwd_d_rs, FWD_RF);
        tick();
        check("shadow_rst_fwd_e_rs", bus.fwd_e_rs, FWD_RF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipelined MIPS core (F/D/E/M/W, one branch delay slot, no flush needed).
- Tracks, for every in-flight instruction, the destination register and cycles until its result is ready (Tnew) in internal E/M/W shadow registers.
- Compares these against D-stage operand demand (Tuse) and drives the stall, the bubble and the forwarding-mux selects.
- Also sequences the multiply/divide unit busy window and stalls HI/LO consumers during it.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after leaving E.
- DIV_CYCLES, 10, busy cycles for div/divu after leaving E.
- CNT_W, 4, width of the MDU busy counter; must hold DIV_CYCLES.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- d_rs  in  5  D-stage rs index.
- d_rt  in  5  D-stage rt index.
- d_rs_use  in  1  D instruction reads rs.
- d_rt_use  in  1  D instruction reads rt.
- d_tuse_rs  in  2  cycles until rs is needed (0 = in D, 1 = in E, 2 = in M).
- d_tuse_rt  in  2  same for rt.
- d_dst  in  5  D-stage destination (0 = none).
- d_tnew  in  2  cycles after entering E until result ready (0 jal/lui-class, 1 ALU, 2 load).
- d_md_start  in  1  D instruction is mult/multu/div/divu.
- d_md_div  in  1  qualifies d_md_start: 1 = div, 0 = mult.
- d_md_use  in  1  D instruction is mfhi/mflo/mthi/mtlo or an md start.
- stall  out  1  freeze PC and F/D register; insert bubble into E.
- fwd_d_rs, fwd_d_rt  out  2  D-operand source: 0 regfile, 1 E, 2 M, 3 W.
- fwd_e_rs, fwd_e_rt  out  2  E-operand source: 0 pipe register, 2 M, 3 W.
- md_busy  out  1  MDU counter nonzero.

Behaviour:
- Shadow registers: e_dst/e_tnew/e_md/e_div, m_dst/m_tnew, w_dst.
- Reset: all shadow registers 0, counter 0. Outputs after reset: stall 0, all fwd 0, md_busy 0.
- Every cycle W<=M, M<=E with tnew decremented (saturating at 0).
- E<=D fields when stall=0. When stall=1, E<=bubble (dst 0, tnew 0, md 0).
- Operand stall for rs, and likewise rt: use && rs!=0 && ((e_dst==rs && e_tnew>d_tuse_rs) || (m_dst==rs && m_tnew>d_tuse_rs)).
- MDU stall: d_md_use && (e_md || md_busy).
- stall = OR of the three stall terms. It is combinational, same cycle.
- The register file has no internal write bypass, so W forwarding is mandatory.
- D forwarding, per operand, nearest stage wins when its dst matches and is nonzero:
  - E if e_tnew==0;
  - else M if m_tnew==0;
  - else W;
  - else 0.
- E forwarding uses the same rules with M, then W, then 0, applied to the E-stage copies of rs/rt. These copies are latched inside the block alongside the E registers, including use bits.
- Register 0 is never forwarded and never stalls.
- MDU counter: when e_md=1, the counter loads DIV_CYCLES or MULT_CYCLES on the next edge. It then decrements to 0. md_busy = counter!=0.
- Simultaneous load and nonzero counter cannot occur because the MDU stall prevents it. If it does occur, load wins.
- Reset asserted mid-operation (stall active, counter running) clears everything on that edge. stall is 0 from the next cycle.

Optional Feature:
- Macro FWD_EN.
- Defined: forwarding as above.
- Undefined: all fwd outputs tied 0, and the operand stall becomes "dst matches in E, M or W" regardless of Tnew/Tuse, i.e. wait until the value is written back.
- MDU logic is unchanged in both builds.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3;
  - Tuse/Tnew encodings;
  - a struct for stage shadow fields {dst, tnew, rs, rt, rs_use, rt_use, md, div}.
- One natural sub-module, md_busy_cnt: load/decrement counter producing md_busy.

Test Plan:
- lw $1,0($0) in E, then D=add $2,$1,$3 (tuse 1) -> stall=1 for one cycle. Next cycle the add is still in D and the lw is in M with tnew 1 -> no stall, and the add later gets fwd_e_rs=FWD_M... no: the add enters E when the lw is in W -> fwd_e_rs=3.
- ori $1,$0,5 in E, then D=beq $1,$1 (tuse 0) -> stall=1 one cycle, then fwd_d_rs=fwd_d_rt=2 (M).
- jal in E (dst 31, tnew 0), D=jr $31 -> stall=0, fwd_d_rs=1.
- div in E, then D=mflo -> stall=1 for 1+10 cycles, md_busy high for exactly 10 cycles. mult gives 1+5.
- add $0,... in E, D reads $0 -> stall=0, fwd all 0.
- reset=1 while counter=7 and stall=1 -> next cycle md_busy=0, stall=0, and the shadow registers are cleared.
- FWD_EN undefined: ori $1 then add $2,$1,$1 -> stall 3 cycles, fwd always 0.
